// File: rtl/cam_capture444.sv
// cam_capture444: captures an 8-bit camera stream (two bytes per RGB444 pixel) into a linear frame buffer.
// Build option CAM_CAPTURE_FRAME_SKIP_EN: capture only every second start of frame.
module cam_capture444 #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic [16:0] frame_addr,
  output logic [15:0] frame_pixel,
  output logic        frame_we,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [16:0] FRAME_PIX   = 17'(H_PIX * V_LINES);
  localparam logic [16:0] LINE_PIX    = 17'(H_PIX);
  localparam logic [16:0] FRAME_LINES = 17'(V_LINES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic        vsync_r, vsync_d_r, href_r, href_d_r;
  logic        vs_rise_s, vs_fall_s, hr_rise_s, hr_fall_s;
  logic        start_s, sof_s, eof_s, pix_en_s;
  logic        phase_r;
  logic [3:0]  red_r;
  logic [16:0] addr_r, pix_cnt_r, line_cnt_r;

  assign vs_rise_s = vsync_r & ~vsync_d_r;
  assign vs_fall_s = ~vsync_r & vsync_d_r;
  assign hr_rise_s = href_r & ~href_d_r;
  assign hr_fall_s = ~href_r & href_d_r;

  // single register stage on sync inputs plus delayed copies for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r   <= 1'b0;
      vsync_d_r <= 1'b0;
      href_r    <= 1'b0;
      href_d_r  <= 1'b0;
    end else begin
      vsync_r   <= cam_vsync;
      vsync_d_r <= vsync_r;
      href_r    <= cam_href;
      href_d_r  <= href_r;
    end
  end

`ifdef CAM_CAPTURE_FRAME_SKIP_EN
  logic skip_r;
  // alternates captured/skipped starts of frame; re-arming always captures the first one
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_r <= 1'b0;
    end else if (start_s) begin
      skip_r <= 1'b0;
    end else if (state_r == WAIT_SOF && vs_fall_s) begin
      skip_r <= ~skip_r;
    end
  end
`endif

  // state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    sof_s        = 1'b0;
    eof_s        = 1'b0;
    pix_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_en) begin
          state_next_s = WAIT_SOF;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_SOF: begin
        if (vs_fall_s) begin
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
          if (!skip_r) begin
            state_next_s = ACTIVE;
            sof_s        = 1'b1;
          end else begin
            state_next_s = WAIT_SOF;
          end
`else
          state_next_s = ACTIVE;
          sof_s        = 1'b1;
`endif
        end else begin
          state_next_s = WAIT_SOF;
        end
      end
      ACTIVE: begin
        // any vsync edge wins over href activity in the same cycle
        if (vs_rise_s) begin
          state_next_s = FLUSH;
          eof_s        = 1'b1;
        end else if (vs_fall_s) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = ACTIVE;
          pix_en_s     = 1'b1;
        end
      end
      FLUSH: begin
        if (capture_en) state_next_s = WAIT_SOF;
        else            state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // byte pairing, address generation, line/pixel bookkeeping and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_addr  <= 17'd0;
      frame_pixel <= 16'd0;
      frame_we    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      phase_r     <= 1'b0;
      red_r       <= 4'd0;
      addr_r      <= 17'd0;
      pix_cnt_r   <= 17'd0;
      line_cnt_r  <= 17'd0;
    end else begin
      frame_we   <= 1'b0;
      frame_done <= eof_s;
      busy       <= (state_next_s != IDLE);
      if (start_s) frame_err <= 1'b0;
      if (sof_s) begin
        addr_r     <= 17'd0;
        phase_r    <= 1'b0;
        pix_cnt_r  <= 17'd0;
        line_cnt_r <= 17'd0;
      end
      if (eof_s && (line_cnt_r != FRAME_LINES)) frame_err <= 1'b1;
      if (pix_en_s) begin
        if (hr_fall_s) begin
          line_cnt_r <= line_cnt_r + 17'd1;
          phase_r    <= 1'b0;
          if (phase_r || (pix_cnt_r != LINE_PIX)) frame_err <= 1'b1;
        end else if (href_r) begin
          if (hr_rise_s || !phase_r) begin
            red_r   <= cam_data[3:0];
            phase_r <= 1'b1;
            if (hr_rise_s) pix_cnt_r <= 17'd0;
          end else begin
            phase_r   <= 1'b0;
            pix_cnt_r <= pix_cnt_r + 17'd1;
            // buffer full: drop the pixel rather than wrap
            if (addr_r < FRAME_PIX) begin
              frame_we    <= 1'b1;
              frame_pixel <= {4'b0000, red_r, cam_data};
              frame_addr  <= addr_r;
              addr_r      <= addr_r + 17'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture444.sv
// Directed self-checking bench for cam_capture444 using a small 4x3 frame geometry.
module tb_cam_capture444;

  localparam int H = 4;
  localparam int V = 3;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        capture_en = 1'b0;
  logic [16:0] frame_addr;
  logic [15:0] frame_pixel;
  logic        frame_we, frame_done, frame_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt, done_cnt, seq_bad, pix_bad, tot_we, tot_done;
  logic [16:0] exp_addr, last_addr;
  logic [15:0] exp_pix;

  cam_capture444 #(.H_PIX(H), .V_LINES(V)) dut (
    .pclk(pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_en(capture_en), .frame_addr(frame_addr),
    .frame_pixel(frame_pixel), .frame_we(frame_we), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // write/done monitor: expects linear addresses from 0 and the current expected pixel
  always @(posedge pclk) begin
    #1;
    if (frame_we) begin
      if (frame_addr !== exp_addr) seq_bad = seq_bad + 1;
      if (frame_pixel !== exp_pix) pix_bad = pix_bad + 1;
      last_addr = frame_addr;
      exp_addr  = exp_addr + 17'd1;
      we_cnt    = we_cnt + 1;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic clr();
    we_cnt = 0; done_cnt = 0; seq_bad = 0; pix_bad = 0;
    exp_addr = 17'd0; last_addr = 17'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
  endtask

  // data trails href by one cycle because href is registered before data is sampled
  task automatic line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i <= nbytes; i++) begin
      cam_href = (i < nbytes);
      cam_data = (i == 0) ? 8'h00 : ((((i - 1) % 2) == 0) ? b0 : b1);
      cyc(1);
    end
    cam_href = 1'b0;
    cyc(2);
  endtask

  task automatic frame(input int nl, input int bad_short, input int bad_odd, input int drop,
                       input logic [7:0] b0, input logic [7:0] b1);
    cam_vsync = 1'b1; cyc(3);
    cam_vsync = 1'b0; cyc(3);
    for (int l = 0; l < nl; l++) begin
      if (l == drop) capture_en = 1'b0;
      line((l == bad_short) ? 2*H-2 : ((l == bad_odd) ? 2*H+1 : 2*H), b0, b1);
      if (l == bad_short || l == bad_odd) chk("err_after_bad_line", 32'(frame_err), 32'd1);
    end
    cam_vsync = 1'b1; cyc(4);
  endtask

  initial begin
    clr();
    exp_pix = 16'h0A5C;
    cyc(2);
    chk("rst_addr", 32'(frame_addr), 32'd0);
    chk("rst_pixel", 32'(frame_pixel), 32'd0);
    chk("rst_we", 32'(frame_we), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; cyc(3);
    chk("idle_busy", 32'(busy), 32'd0);
    capture_en = 1'b1; cyc(2);
    chk("armed_busy", 32'(busy), 32'd1);

    // full frame, pairs 0x0A,0x5C
    frame(V, -1, -1, -1, 8'h0A, 8'h5C);
    chk("full_writes", 32'(we_cnt), 32'(H*V));
    chk("full_last_addr", 32'(last_addr), 32'(H*V-1));
    chk("full_seq", 32'(seq_bad), 32'd0);
    chk("full_pixel", 32'(pix_bad), 32'd0);
    chk("full_done", 32'(done_cnt), 32'd1);
    chk("full_err", 32'(frame_err), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);

    // short line; upper nibble of byte 0 must be dropped
    do_reset(); clr(); exp_pix = 16'h07C1;
    frame(V, 1, -1, -1, 8'h37, 8'hC1);
    chk("short_writes", 32'(we_cnt), 32'(H*V-1));
    chk("short_pixel", 32'(pix_bad), 32'd0);
    chk("short_done", 32'(done_cnt), 32'd1);
    chk("short_err", 32'(frame_err), 32'd1);

    // one line too many: writes stop at the last address
    do_reset(); clr(); exp_pix = 16'h0A5C;
    frame(V+1, -1, -1, -1, 8'h0A, 8'h5C);
    chk("over_writes", 32'(we_cnt), 32'(H*V));
    chk("over_last_addr", 32'(last_addr), 32'(H*V-1));
    chk("over_seq", 32'(seq_bad), 32'd0);
    chk("over_err", 32'(frame_err), 32'd1);
    chk("over_done", 32'(done_cnt), 32'd1);

    // odd trailing byte
    do_reset(); clr();
    frame(V, -1, 0, -1, 8'h0A, 8'h5C);
    chk("odd_writes", 32'(we_cnt), 32'(H*V));
    chk("odd_err", 32'(frame_err), 32'd1);

    // capture_en dropped mid-frame: frame completes, then idle
    do_reset(); clr();
    frame(V, -1, -1, 1, 8'h0A, 8'h5C);
    chk("drop_writes", 32'(we_cnt), 32'(H*V));
    chk("drop_done", 32'(done_cnt), 32'd1);
    chk("drop_err", 32'(frame_err), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    clr();
    frame(V, -1, -1, -1, 8'h0A, 8'h5C);
    chk("idle_writes", 32'(we_cnt), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd0);
    chk("idle_busy2", 32'(busy), 32'd0);

    // reset in the middle of a frame
    capture_en = 1'b1; do_reset(); clr(); cyc(1);
    cam_vsync = 1'b1; cyc(3); cam_vsync = 1'b0; cyc(3);
    line(2*H, 8'h0A, 8'h5C);
    chk("mid_addr_pre", 32'(frame_addr), 32'(H-1));
    rst_n = 1'b0; #1;
    chk("mid_rst_addr", 32'(frame_addr), 32'd0);
    chk("mid_rst_pixel", 32'(frame_pixel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cyc(2); rst_n = 1'b1; cyc(1); clr();
    frame(V, -1, -1, -1, 8'h0A, 8'h5C);
    chk("after_rst_writes", 32'(we_cnt), 32'(H*V));
    chk("after_rst_seq", 32'(seq_bad), 32'd0);
    chk("after_rst_done", 32'(done_cnt), 32'd1);

    // four back-to-back frames
    do_reset(); tot_we = 0; tot_done = 0;
    for (int f = 0; f < 4; f++) begin
      clr();
      frame(V, -1, -1, -1, 8'h0A, 8'h5C);
      chk("multi_seq", 32'(seq_bad), 32'd0);
      tot_we = tot_we + we_cnt;
      tot_done = tot_done + done_cnt;
    end
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    chk("multi_writes", 32'(tot_we), 32'(2*H*V));
    chk("multi_done", 32'(tot_done), 32'd2);
`else
    chk("multi_writes", 32'(tot_we), 32'(4*H*V));
    chk("multi_done", 32'(tot_done), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_capture444.md
CAM_CAPTURE444 -- requirements
Module: cam_capture444

Interface
REQ-001 SHALL have parameter H_PIX, default 320, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 240, lines per frame.
REQ-003 SHALL have port pclk, input, 1, camera pixel clock and the only clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cam_vsync (input, 1, frame sync, active high), cam_href (input, 1, line valid) and cam_data (input, 8, camera byte).
REQ-006 SHALL have port capture_en, input, 1, level request to capture frames.
REQ-007 SHALL have ports frame_addr (output, 17, frame-buffer write address), frame_pixel (output, 16, {4'b0,R,G,B}) and frame_we (output, 1, write strobe).
REQ-008 SHALL have ports frame_done (output, 1, one-cycle pulse at the end of a captured frame), frame_err (output, 1, sticky size error) and busy (output, 1, state is not IDLE).

Function
REQ-009 SHALL register cam_vsync and cam_href once, detect edges on the registered copies, and sample cam_data in the same cycle the registered href is high.
REQ-010 SHALL use states IDLE, WAIT_SOF, ACTIVE and FLUSH.
REQ-011 SHALL move IDLE->WAIT_SOF when capture_en=1, and WAIT_SOF->ACTIVE on a vsync falling edge (start of frame), clearing address, byte phase, pixel and line counters.
REQ-012 SHALL, in ACTIVE, treat byte 0 of each pair as xxxxRRRR and byte 1 as GGGGBBBB, with the byte phase reset to 0 on every href rising edge.
REQ-013 SHALL assert frame_we for exactly one cycle, one cycle after byte 1 is sampled, with frame_pixel={4'b0,R,G,B} and frame_addr equal to the current write address.
REQ-014 SHALL increment the address after each write, so the first write is at address 0 and addresses run linearly to H_PIX*V_LINES-1.
REQ-015 SHALL suppress writes once the address reaches H_PIX*V_LINES (no wrap) and set frame_err.
REQ-016 SHALL count lines on href falling edges and pixels per line, and set frame_err when a line length differs from H_PIX.
REQ-017 SHALL, on a vsync rising edge in ACTIVE, go to FLUSH; set frame_err if the line count differs from V_LINES; pulse frame_done on the following cycle.
REQ-018 SHALL leave FLUSH after one cycle, to WAIT_SOF if capture_en=1 and to IDLE otherwise.
REQ-019 SHALL have capture_en deasserted mid-frame take effect only at FLUSH (the current frame completes).
REQ-020 SHALL ignore an odd trailing byte at an href falling edge (no write) and set frame_err.
REQ-021 SHALL have frame_err cleared only by reset or on an IDLE->WAIT_SOF transition.
REQ-022 SHALL give an href edge and a vsync edge in the same cycle the vsync edge priority; no pixel is written in that cycle.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, frame_addr=0, frame_pixel=0, frame_we=0, frame_done=0, frame_err=0, busy=0, and all counters and sync registers to 0.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame immediately; after release the block waits for a new vsync falling edge and never resumes a partial frame.

Configuration
REQ-025 SHALL, when macro CAM_CAPTURE_FRAME_SKIP_EN is defined, capture only every second start of frame; on skipped frames it stays in WAIT_SOF, frame_we stays 0 and frame_done does not pulse; the first frame after IDLE is captured.
REQ-026 SHALL, when CAM_CAPTURE_FRAME_SKIP_EN is undefined, capture every frame while capture_en=1.

Verification
REQ-027 SHALL cover: capture_en=1 with a full 320x240 frame where byte pairs are 0x0A,0x5C -> 76800 writes of 0x0A5C at addresses 0..76799, one frame_done, frame_err=0.
REQ-028 SHALL cover: a 319-pixel line within a frame -> frame_err=1 after that line; frame_done still pulses at vsync.
REQ-029 SHALL cover: 241 lines of 320 pixels -> writes stop at address 76799, frame_err=1, no write to address 76800.
REQ-030 SHALL cover: capture_en dropped at line 100 -> frame completes with 76800 writes, then IDLE with busy=0 and no writes on the next frame.
REQ-031 SHALL cover: rst_n pulsed low at line 50 -> all outputs 0 at once; the next complete frame starts again at address 0.
REQ-032 SHALL cover: CAM_CAPTURE_FRAME_SKIP_EN defined over 4 frames -> frames 1 and 3 written, 2 frame_done pulses.
